ym2203_bus_ctrl: RTL and testbench
==================================

# ym2203_bus_ctrl

Write scheduler and port decoder sitting between the Spectrum CPU port bus and two ym2203 instances (TurboSound FM). It decodes chip-select writes and queues register/data writes in a small FIFO. It replays them to the selected chip at the pace the YM2203 requires: address and data busy times counted in master-clock `CE` ticks. It also routes reads back from the selected chip. The CPU never has to poll the busy flag.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `ADDR_WAIT`, 17: `CE` ticks idle after an address write.
- `DATA_WAIT_FM`, 83: `CE` ticks after a data write to register ≥ 0x10.
- `DATA_WAIT_PSG`, 2: `CE` ticks after a data write to register < 0x10.

Ports:
- `CLK` in 1: single clock. Synchronous, active-high reset; one clock domain.
- `RESET` in 1: synchronous, active-high reset.
- `CE` in 1: master clock enable, the same strobe fed to ym2203 `CE`.
- `CPU_WR` in 1: one-cycle write strobe.
- `CPU_RD` in 1: one-cycle read strobe.
- `CPU_A` in 1: port select, 0 = register/select port (FFFD), 1 = data port (BFFD).
- `CPU_DI` in 8: write data.
- `CPU_DO` out 8: read data.
- `CPU_BUSY` out 1: CPU wait request.
- `OVERRUN` out 1: one-cycle pulse when a write is dropped.
- `YM_SEL` out 1: target chip of the current access.
- `YM_A0` out 1: ym2203 `A0`.
- `YM_WE` out 1: ym2203 `WE`.
- `YM_DI` out 8: ym2203 `DI`.
- `YM0_DO` in 8: ym2203 `DO`, chip 0.
- `YM1_DO` in 8: ym2203 `DO`, chip 1.

## Operation
- **Chip select.** A `CPU_WR` with `CPU_A`=0 and `CPU_DI[7:3]`=5'b11111 is a control write.
  - Sets `sel` <= ~`CPU_DI[0]` (0xFF → chip 0, 0xFE → chip 1).
  - Not queued; takes effect the next cycle.
- **Queued writes.** Any other `CPU_WR` enqueues {`sel`, `CPU_A`, `CPU_DI`}. The chip tag is captured at enqueue time.
- **Overrun.** A write is dropped, with `OVERRUN` pulsed the next cycle, when the FIFO is full and no pop happens that cycle.
- **Full with pop.** When full with a pop in the same cycle, the write is accepted.
- **FSM states and transitions.**
  - IDLE → ISSUE when the FIFO is non-empty.
  - ISSUE: drive the head entry, `YM_WE`=1 for exactly one `CLK` cycle, pop; → WAIT.
  - WAIT: counter loaded at ISSUE, decremented on each `CE`; → IDLE at the cycle the counter reaches 0.
- **Wait load value.**
  - A0=0 → `ADDR_WAIT`.
  - A0=1 → `DATA_WAIT_FM` if `shadow[chip]` ≥ 0x10, else `DATA_WAIT_PSG`.
  - `shadow[chip]` (8 bit per chip) is updated on every issued address write.
- **Global busy window.** The wait covers both chips.
- **Reads.**
  - `CPU_BUSY` = FIFO non-empty, or FSM ≠ IDLE, or FIFO full.
  - While IDLE with an empty FIFO: `YM_SEL`=`sel`, `YM_A0`=`CPU_A`, `YM_WE`=0.
  - `CPU_DO` = `sel` ? `YM1_DO` : `YM0_DO` (combinational).
  - A `CPU_RD` while `CPU_BUSY` returns undefined data; the CPU must honour `CPU_BUSY`.
- **Reset.**
  - FIFO empty, `sel`=0, IDLE, counter=0, shadows=0.
  - Outputs: `YM_WE`=0, `YM_A0`=0, `YM_DI`=0, `YM_SEL`=0, `OVERRUN`=0, `CPU_BUSY`=0.
  - Mid-operation reset discards queued writes and any partial wait; no `YM_WE` in the reset cycle or the cycle after.

## Timing
- **Write to strobe.** Write at cycle t into an empty FIFO in IDLE → `YM_WE`=1 during t+1. Latency 1 `CLK`.
- **Issue spacing.** Back-to-back issues are separated by ≥ wait+1 `CLK` cycles.
- **Wait counting.** Wait counts `CE` ticks strictly after the ISSUE cycle. A `CE` coinciding with ISSUE is not counted.
- **Zero wait.** A wait of 0 returns to IDLE the cycle after ISSUE.
- **FIFO pointers.** Pointers wrap modulo `DEPTH`; count is `$clog2(DEPTH)+1` bits.
- **Select and queue.** A control write and a pending FIFO entry do not interact; the entry keeps its captured chip tag.

## Structure
- **Package `ym_ctrl_pkg`:**
  - `state_t` enum {IDLE, ISSUE, WAIT}.
  - `wr_entry_t` struct {chip, a0, data[7:0]}.
  - Default wait constants and the 0x10 FM/PSG register boundary.
- **Sub-module `ym_wr_fifo`:** synchronous FIFO of `wr_entry_t`, same `CLK`/`RESET`, with push/pop/full/empty/head outputs.
- **Top level:** FSM, wait counter, shadows and muxes.

## Test plan
- **Basic write.** Write A=0 0x28 then A=1 0x01 → `YM_WE` pulse with A0=0/DI=0x28. Then 17 `CE` ticks of no strobe. Then A0=1/DI=0x01 pulse; `CPU_BUSY` falls 83 `CE` ticks later.
- **PSG wait.** Address 0x07, data 0x38 → data wait of 2 `CE` ticks only.
- **Select.**
  - Write 0xFE to A=0 → no `YM_WE`.
  - Following writes carry `YM_SEL`=1.
  - Read A=1 returns `YM1_DO`.
  - 0xFF restores chip 0.
- **Overrun.** Fill 4 entries during a wait, write a 5th → `OVERRUN` pulse. Only the 4 entries are issued, in order.
- **Full with pop.** Full FIFO with a write on the ISSUE (pop) cycle → write accepted, no `OVERRUN`.
- **Reset mid-operation.** Assert `RESET` mid-WAIT with 3 queued entries → no further `YM_WE`. All outputs at reset values; `CPU_BUSY`=0 the cycle after reset.

Source files
------------

// File: rtl/ym_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ym_ctrl_pkg
// Description : Shared types and default timing for the ym2203 write scheduler
// Revision    : 1.0 - initial release
// ============================================================================
package ym_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       chip;
        logic       a0;
        logic [7:0] data;
    } wr_entry_t;

    localparam int         c_ADDR_WAIT_DEF     = 17;
    localparam int         c_DATA_WAIT_FM_DEF  = 83;
    localparam int         c_DATA_WAIT_PSG_DEF = 2;
    // Registers below this index belong to the SSG block and settle quickly
    localparam logic [7:0] c_FM_REG_BASE       = 8'h10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ym_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ym_wr_fifo
// Description : Synchronous FIFO of queued chip writes, push accepted when full
//               if a pop happens in the same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ym_wr_fifo
    import ym_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RESET,
    input  logic      i_push,
    input  logic      i_pop,
    input  wr_entry_t i_din,
    output wr_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

    wr_entry_t         r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ym2203_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ym2203_bus_ctrl
// Description : TurboSound FM port decoder and paced write scheduler for two
//               ym2203 chips
// Revision    : 1.0 - initial release
// ============================================================================
module ym2203_bus_ctrl
    import ym_ctrl_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ADDR_WAIT     = c_ADDR_WAIT_DEF,
    parameter int DATA_WAIT_FM  = c_DATA_WAIT_FM_DEF,
    parameter int DATA_WAIT_PSG = c_DATA_WAIT_PSG_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic       CPU_WR,
    input  logic       CPU_RD,
    input  logic       CPU_A,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_BUSY,
    output logic       OVERRUN,
    output logic       YM_SEL,
    output logic       YM_A0,
    output logic       YM_WE,
    output logic [7:0] YM_DI,
    input  logic [7:0] YM0_DO,
    input  logic [7:0] YM1_DO
);

    localparam int c_WAIT_MAX = max3(ADDR_WAIT, DATA_WAIT_FM, DATA_WAIT_PSG);
    localparam int c_CNT_W    = (c_WAIT_MAX < 2) ? 1 : $clog2(c_WAIT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ADDR_LD = c_CNT_W'(ADDR_WAIT);
    localparam logic [c_CNT_W-1:0] c_FM_LD   = c_CNT_W'(DATA_WAIT_FM);
    localparam logic [c_CNT_W-1:0] c_PSG_LD  = c_CNT_W'(DATA_WAIT_PSG);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0][7:0]      r_shadow;
    logic                 r_sel;
    logic                 r_overrun;
    logic                 r_we;
    logic                 r_a0;
    logic [7:0]           r_di;
    logic                 r_ysel;

    logic                 w_ctrl_wr;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_idle_empty;
    wr_entry_t            w_din;
    wr_entry_t            w_head;
    wr_entry_t            w_next;
    logic [c_CNT_W-1:0]   w_load;
    logic                 w_unused;

    // Reads are a plain mux on the selected chip, so the strobe itself is inert
    assign w_unused = CPU_RD;

    assign w_ctrl_wr  = CPU_WR && !CPU_A && (CPU_DI[7:3] == 5'b11111);
    assign w_push_req = CPU_WR && !w_ctrl_wr;
    assign w_pop      = (r_state == ISSUE) && !w_empty;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_din      = '{chip: r_sel, a0: CPU_A, data: CPU_DI};
    // An empty FIFO in IDLE forwards the incoming write so the strobe follows next cycle
    assign w_next     = w_empty ? w_din : w_head;

    ym_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_load = c_ADDR_LD;
        if (w_head.a0) begin
            w_load = (r_shadow[w_head.chip] >= c_FM_REG_BASE) ? c_FM_LD : c_PSG_LD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_sel     <= 1'b0;
            r_overrun <= 1'b0;
            r_we      <= 1'b0;
            r_a0      <= 1'b0;
            r_di      <= 8'h00;
            r_ysel    <= 1'b0;
        end else begin
            r_overrun <= w_push_req && w_full && !w_pop;
            if (w_ctrl_wr) begin
                r_sel <= ~CPU_DI[0];
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty || w_push) begin
                        r_state <= ISSUE;
                        r_we    <= 1'b1;
                        r_ysel  <= w_next.chip;
                        r_a0    <= w_next.a0;
                        r_di    <= w_next.data;
                    end
                end
                ISSUE: begin
                    r_we  <= 1'b0;
                    r_cnt <= w_load;
                    if (!w_head.a0) begin
                        r_shadow[w_head.chip] <= w_head.data;
                    end
                    r_state <= (w_load == '0) ? IDLE : WAIT;
                end
                WAIT: begin
                    if (CE) begin
                        if (r_cnt <= c_ONE) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign w_idle_empty = (r_state == IDLE) && w_empty;

    assign CPU_DO   = r_sel ? YM1_DO : YM0_DO;
    assign CPU_BUSY = !w_empty || (r_state != IDLE) || w_full;
    assign OVERRUN  = r_overrun;
    assign YM_WE    = r_we && !RESET;
    assign YM_SEL   = w_idle_empty ? r_sel : r_ysel;
    assign YM_A0    = w_idle_empty ? CPU_A : r_a0;
    assign YM_DI    = r_di;

endmodule
`default_nettype wire

// File: tb/tb_ym2203_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ym2203_bus_ctrl
// Description : Randomised scoreboard bench for the ym2203 write scheduler
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ym2203_bus_ctrl;

    localparam int c_DEPTH = 4;
    localparam int c_AW    = 17;
    localparam int c_FMW   = 83;
    localparam int c_PSGW  = 2;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b1;
    logic       CE     = 1'b0;
    logic       CPU_WR = 1'b0;
    logic       CPU_RD = 1'b0;
    logic       CPU_A  = 1'b0;
    logic [7:0] CPU_DI = 8'h00;
    logic [7:0] YM0_DO = 8'h00;
    logic [7:0] YM1_DO = 8'h00;
    logic [7:0] CPU_DO;
    logic       CPU_BUSY;
    logic       OVERRUN;
    logic       YM_SEL;
    logic       YM_A0;
    logic       YM_WE;
    logic [7:0] YM_DI;

    ym2203_bus_ctrl #(
        .DEPTH         (c_DEPTH),
        .ADDR_WAIT     (c_AW),
        .DATA_WAIT_FM  (c_FMW),
        .DATA_WAIT_PSG (c_PSGW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CE       (CE),
        .CPU_WR   (CPU_WR),
        .CPU_RD   (CPU_RD),
        .CPU_A    (CPU_A),
        .CPU_DI   (CPU_DI),
        .CPU_DO   (CPU_DO),
        .CPU_BUSY (CPU_BUSY),
        .OVERRUN  (OVERRUN),
        .YM_SEL   (YM_SEL),
        .YM_A0    (YM_A0),
        .YM_WE    (YM_WE),
        .YM_DI    (YM_DI),
        .YM0_DO   (YM0_DO),
        .YM1_DO   (YM1_DO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic       chip;
        logic       a0;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        int   t;
        logic chk;
        logic busy;
        logic sel;
        logic idle_empty;
    } cyc_exp_t;

    // Reference model: pending writes with their push cycle, plus the cycle at
    // which the chips become free again (-1 while a busy window is running).
    ent_t       mq[$];
    ent_t       exp_wr[$];
    int         exp_ovr[$];
    cyc_exp_t   exp_cyc[$];
    int         m_free  = 0;
    int         m_ticks = 0;
    logic       m_sel   = 1'b0;
    logic [7:0] m_shadow [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int a, input int e);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d at cycle %0d", name, a, e, cyc);
    endtask

    task automatic model(input int c, input logic rst, input logic ce,
                         input logic wr, input logic a, input logic [7:0] di);
        cyc_exp_t e;
        ent_t     h;
        ent_t     ne;
        bit       issue;
        bit       full;
        int       w;
        e.t   = c;
        e.sel = m_sel;
        if (rst) begin
            e.chk        = 1'b0;
            e.busy       = 1'b0;
            e.idle_empty = 1'b0;
            exp_cyc.push_back(e);
            mq.delete();
            m_free      = c + 1;
            m_ticks     = 0;
            m_sel       = 1'b0;
            m_shadow[0] = 8'h00;
            m_shadow[1] = 8'h00;
            return;
        end
        issue        = (mq.size() > 0) && (mq[0].t < c) && (m_free >= 0) && (m_free < c);
        e.chk        = 1'b1;
        e.busy       = (mq.size() > 0) || (m_free < 0) || (m_free > c);
        e.idle_empty = !e.busy;
        exp_cyc.push_back(e);
        full = (mq.size() == c_DEPTH);
        if (issue) begin
            h = mq.pop_front();
            if (!h.a0) begin
                w = c_AW;
                m_shadow[h.chip] = h.d;
            end else begin
                w = (m_shadow[h.chip] >= 8'h10) ? c_FMW : c_PSGW;
            end
            h.t = c;
            exp_wr.push_back(h);
            if (w == 0) begin
                m_free = c + 1;
            end else begin
                m_free  = -1;
                m_ticks = w;
            end
        end else if (m_free < 0 && ce) begin
            m_ticks--;
            if (m_ticks == 0) m_free = c + 1;
        end
        if (wr) begin
            if (!a && di[7:3] == 5'b11111) begin
                m_sel = ~di[0];
            end else if (!full || issue) begin
                ne.t    = c;
                ne.chip = m_sel;
                ne.a0   = a;
                ne.d    = di;
                mq.push_back(ne);
            end else begin
                exp_ovr.push_back(c + 1);
            end
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic a, input logic [7:0] di);
        @(posedge CLK);
        #1;
        RESET  = rst;
        CPU_WR = wr;
        CPU_A  = a;
        CPU_DI = di;
        CE     = 1'($urandom % 2);
        CPU_RD = 1'($urandom % 2);
        YM0_DO = 8'($urandom);
        YM1_DO = 8'($urandom);
        model(cyc, rst, CE, wr, a, di);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!(mq.size() == 0 && m_free >= 0) && n < limit) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= limit) fail_now("drain_timeout", n, limit);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic logic [7:0] rnd_data();
        case ($urandom % 8)
            0:       return 8'hFE;
            1:       return 8'hFF;
            2, 3:    return 8'($urandom % 16);
            default: return 8'($urandom);
        endcase
    endfunction

    cyc_exp_t me;
    ent_t     mw;
    int       mo;

    always @(negedge CLK) begin
        if (exp_cyc.size() > 0) begin
            me = exp_cyc.pop_front();
            if (me.chk) chk("cpu_busy", 32'(CPU_BUSY), 32'(me.busy));
            chk("cpu_do", 32'(CPU_DO), 32'(me.sel ? YM1_DO : YM0_DO));
            if (me.idle_empty) begin
                chk("ym_sel_idle", 32'(YM_SEL), 32'(me.sel));
                chk("ym_a0_idle", 32'(YM_A0), 32'(CPU_A));
            end
        end
        while (exp_wr.size() > 0 && exp_wr[0].t < cyc) begin
            mw = exp_wr.pop_front();
            fail_now("missing_we", cyc, mw.t);
        end
        if (YM_WE !== 1'b0) begin
            if (exp_wr.size() == 0) begin
                fail_now("unexpected_we", 1, 0);
            end else begin
                mw = exp_wr.pop_front();
                chk("we_cycle", 32'(cyc), 32'(mw.t));
                chk("we_sel", 32'(YM_SEL), 32'(mw.chip));
                chk("we_a0", 32'(YM_A0), 32'(mw.a0));
                chk("we_di", 32'(YM_DI), 32'(mw.d));
            end
        end
        while (exp_ovr.size() > 0 && exp_ovr[0] < cyc) begin
            mo = exp_ovr.pop_front();
            fail_now("missing_overrun", cyc, mo);
        end
        if (OVERRUN !== 1'b0) begin
            if (exp_ovr.size() == 0) begin
                fail_now("unexpected_overrun", 1, 0);
            end else begin
                mo = exp_ovr.pop_front();
                chk("overrun_cycle", 32'(cyc), 32'(mo));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        chk({tag, "_we"},   32'(YM_WE),    32'd0);
        chk({tag, "_a0"},   32'(YM_A0),    32'd0);
        chk({tag, "_di"},   32'(YM_DI),    32'd0);
        chk({tag, "_sel"},  32'(YM_SEL),   32'd0);
        chk({tag, "_ovr"},  32'(OVERRUN),  32'd0);
        chk({tag, "_busy"}, 32'(CPU_BUSY), 32'd0);
    endtask

    initial begin
        m_shadow[0] = 8'h00;
        m_shadow[1] = 8'h00;

        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_reset_outputs("reset");

        // Basic FM write: address then data with long data wait
        step(1'b0, 1'b1, 1'b0, 8'h28);
        step(1'b0, 1'b1, 1'b1, 8'h01);
        drain(3000);

        // SSG register: short data wait
        step(1'b0, 1'b1, 1'b0, 8'h07);
        step(1'b0, 1'b1, 1'b1, 8'h38);
        drain(3000);

        // Select chip 1, write, then back to chip 0
        step(1'b0, 1'b1, 1'b0, 8'hFE);
        step(1'b0, 1'b1, 1'b0, 8'h28);
        step(1'b0, 1'b1, 1'b1, 8'h05);
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        drain(3000);
        step(1'b0, 1'b1, 1'b0, 8'h30);
        drain(3000);

        // Overrun: five writes back to back during an address wait
        step(1'b0, 1'b1, 1'b0, 8'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
        drain(3000);

        // Full with pop: keep writing every cycle so pop cycles coincide with writes
        step(1'b0, 1'b1, 1'b0, 8'h05);
        for (int i = 0; i < 250; i++) step(1'b0, 1'b1, 1'($urandom % 2), 8'($urandom % 64));
        drain(3000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom % 4 == 0) step(1'b0, 1'b1, 1'($urandom % 2), rnd_data());
            else                   step(1'b0, 1'b0, 1'($urandom % 2), 8'h00);
        end
        drain(3000);

        // Reset in the middle of a wait with three entries queued
        step(1'b0, 1'b1, 1'b0, 8'hFE);
        step(1'b0, 1'b1, 1'b0, 8'h50);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_reset_outputs("midreset");
        repeat (40) step(1'b0, 1'b0, 1'($urandom % 2), 8'h00);
        drain(3000);

        chk("leftover_we", 32'(exp_wr.size()), 32'd0);
        chk("leftover_overrun", 32'(exp_ovr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
